// File: rtl/fib_pkg.sv
// fib_pkg: shared types for the Fibonacci stream generator family.
//   state_e : FSM encoding (IDLE waits for a command, STREAM emits terms).
package fib_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/fib_step.sv
// fib_step: one step of a two-term recurrence, next = a + b.
//   Parameters: WIDTH (term width), SATURATE (0 = wrap, 1 = clamp to all-ones).
//   Ports:
//     a, b      in  WIDTH : current pair
//     next_term out WIDTH : resulting term (wrapped or clamped)
//     carry     out 1     : the true sum does not fit in WIDTH bits
module fib_step #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_term,
  output logic             carry
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    carry = sum[WIDTH];
    if (carry && (SATURATE != 0)) begin
      next_term = '1;
    end else begin
      next_term = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fib_stream_gen.sv
// fib_stream_gen: back-pressurable two-term sequence generator.
//   Holds (a, b); each accepted beat emits a, then (a, b) <= (b, a+b).
//   Parameters: WIDTH, CNT_W, SATURATE, SEED_A, SEED_B.
//   Ports:
//     clk, rst              : clock (rising edge), async active-high reset
//     start, len            : begin a burst of len terms (IDLE only, len != 0)
//     seed_load, seed_a/b   : reload the pair and clear ovf (IDLE only)
//     out_valid/ready/data  : output stream, out_data is register a
//     out_last              : final beat of the burst
//     busy                  : FSM is streaming
//     ovf                   : sticky, some sum carried out of WIDTH bits
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 8,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] SEED_A   = WIDTH'(0),
  parameter logic [WIDTH-1:0] SEED_B   = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             ovf
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_term;
  logic             step_carry;
  logic             handshake;

  fib_step #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_step (
    .a         (a_q),
    .b         (b_q),
    .next_term (step_term),
    .carry     (step_carry)
  );

  // Outputs depend only on registered state, never on inputs.
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_last  = (state_q == STREAM) && (rem_q == CNT_W'(1));
  assign out_data  = a_q;
  assign ovf       = ovf_q;

  assign handshake = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        // Seed and start may coincide: the first beat then carries seed_a.
        if (seed_load) begin
          a_d   = seed_a;
          b_d   = seed_b;
          ovf_d = 1'b0;
        end
        if (start && (len != '0)) begin
          state_d = STREAM;
          rem_d   = len;
        end
      end
      STREAM: begin
        if (handshake) begin
          a_d   = b_q;
          b_d   = step_term;
          rem_d = rem_q - CNT_W'(1);
          if (step_carry) begin
            ovf_d = 1'b1;
          end
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= SEED_A;
      b_q     <= SEED_B;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fib_stream_gen.sv
// tb_fib_stream_gen: directed bench for fib_stream_gen. A wrapping and a
// saturating instance share all inputs; the saturating one is only checked
// where the two are expected to differ.
module tb_fib_stream_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len_i = '0;
  logic       seed_load = 1'b0;
  logic [7:0] seed_a = '0;
  logic [7:0] seed_b = '0;
  logic       out_ready = 1'b0;

  logic       out_valid, out_last, busy, ovf;
  logic [7:0] out_data;
  logic       s_out_valid, s_out_last, s_busy, s_ovf;
  logic [7:0] s_out_data;

  int n_chk = 0;
  int n_bad = 0;
  int exp_q[$];
  int exp_s[$];

  always #5 clk = ~clk;

  fib_stream_gen dut (
    .clk(clk), .rst(rst), .start(start), .len(len_i),
    .seed_load(seed_load), .seed_a(seed_a), .seed_b(seed_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  fib_stream_gen #(.SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .len(len_i),
    .seed_load(seed_load), .seed_a(seed_a), .seed_b(seed_b),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy), .ovf(s_ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start (optionally with a seed load) and collects len beats,
  // checking each cycle against exp_q (and exp_s when chk_sat is set).
  task automatic run_burst(input int len, input bit ld, input int sa, input int sb,
                           input bit rnd, input bit chk_sat);
    int  beats;
    int  cycles;
    bit  hs;
    start     = 1'b1;
    len_i     = 8'(len);
    seed_load = ld;
    seed_a    = 8'(sa);
    seed_b    = 8'(sb);
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    beats     = 0;
    cycles    = 0;
    while (beats < len && cycles < 300) begin
      check_val("valid", out_valid, 1);
      check_val("busy", busy, 1);
      check_val("data", out_data, exp_q[beats]);
      check_val("last", out_last, (beats == len - 1) ? 1 : 0);
      if (chk_sat) check_val("sat_data", s_out_data, exp_s[beats]);
      hs = out_ready;
      tick();
      if (hs) beats++;
      cycles++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    check_val("beats_done", beats, len);
    if (!rnd) check_val("burst_cycles", cycles, len);
    check_val("valid_after", out_valid, 0);
    check_val("busy_after", busy, 0);
    $display("burst len=%0d seed_load=%0d rnd_ready=%0d cycles=%0d", len, ld, rnd, cycles);
  endtask

  initial begin
    // Reset state, held across a clock edge.
    tick();
    check_val("rst_valid", out_valid, 0);
    check_val("rst_last", out_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    exp_q = '{0, 1, 1, 2, 3, 5};
    run_burst(6, 0, 0, 0, 0, 0);

    exp_q = '{8, 13, 21};
    run_burst(3, 0, 0, 0, 0, 0);
    check_val("ovf_after_21", ovf, 0);

    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    run_burst(10, 1, 0, 1, 1, 0);
    out_ready = 1'b1;

    exp_q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
    exp_s = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 255};
    run_burst(15, 1, 0, 1, 0, 1);
    check_val("ovf_wrap", ovf, 1);
    check_val("ovf_sat", s_ovf, 1);

    exp_q = '{2, 1, 3, 4, 7};
    run_burst(5, 1, 2, 1, 0, 0);
    check_val("ovf_cleared", ovf, 0);

    // start with len=0: nothing happens.
    start = 1'b1;
    len_i = 8'd0;
    tick();
    start = 1'b0;
    check_val("len0_valid", out_valid, 0);
    check_val("len0_busy", busy, 0);
    tick();
    check_val("len0_valid2", out_valid, 0);
    check_val("len0_data", out_data, 11);
    $display("len=0 start ignored");

    // Reset mid-burst after two beats.
    start = 1'b1; len_i = 8'd6; seed_load = 1'b1; seed_a = 8'd0; seed_b = 8'd1;
    out_ready = 1'b1;
    tick();
    start = 1'b0; seed_load = 1'b0;
    tick();
    tick();
    check_val("pre_rst_data", out_data, 1);
    check_val("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_val("async_rst_valid", out_valid, 0);
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_last", out_last, 0);
    check_val("async_rst_data", out_data, 0);
    #1;
    rst = 1'b0;
    $display("async reset mid-burst");
    tick();
    exp_q = '{0, 1};
    run_burst(2, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
